multicycle_ctrl: RTL and testbench

Multi-cycle RV32I control sequencer for the next-generation core. Unlike the single-cycle decoder, it walks each instruction through FETCH/DECODE/EXEC/MEM/WB states. It stalls on a memory ready handshake and counts retired instructions. It traps on illegal opcodes and, optionally, on memory timeouts. It sits between the instruction register/memory port and the shared datapath (PC, register file, ALU, immediate generator).

---
 rtl/multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle RV32I control sequencer. Walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), stalls on the memory ready
// handshake, counts retired instructions and traps on illegal encodings.
//
// Optional feature: define MCC_MEM_TIMEOUT_EN to add a memory wait watchdog
// that traps with cause 10 after TIMEOUT consecutive cycles without mem_ready.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   TIMEOUT      memory wait limit in cycles (1..65535)
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   instr        instruction register contents (valid from DECODE onward)
//   mem_ready    memory completes the current access this cycle
//   branch_taken datapath branch comparator result (valid in EXEC)
//   ir_write, pc_write, pc_src, reg_write, mem_read, mem_write,
//   mem_addr_sel, alu_src_a, alu_src_b, imm_sel, alu_ctrl, wb_sel
//                datapath controls (combinational from state/instr/inputs)
//   state        current FSM state code
//   trap         high while in TRAP
//   trap_cause   01 illegal instruction, 10 memory timeout, 00 otherwise
//   instret      retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_addr_sel,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3,
    ALU_XOR = 4'h4, ALU_SLL = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7,
    ALU_SLT = 4'h8, ALU_SLTU = 4'h9
  } alu_t;

  typedef enum logic [3:0] {
    C_R, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct3 to ALU op; alt selects SUB over ADD and SRA over SRL.
  function automatic alu_t alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause;
  logic             w_retire;
  logic             w_timeout;

  logic [2:0]       w_f3;
  logic             w_f7b;
  class_t           w_class;
  logic             w_exec_bad;
  alu_t             w_alu;
  logic [1:0]       w_src_a;
  logic             w_src_b;
  logic [2:0]       w_imm;
  logic [1:0]       w_wb;
  logic             w_unused_bits;

  assign w_f3  = instr[14:12];
  assign w_f7b = instr[30];

  // Instruction classification and per-class datapath selects.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path through the case statements can infer a latch.
  always_comb begin
    w_class    = C_BAD;
    w_exec_bad = 1'b0;
    w_alu      = ALU_ADD;
    w_src_a    = 2'b00;
    w_src_b    = 1'b0;
    w_imm      = 3'b000;
    w_wb       = 2'b00;
    case (instr[6:0])
      OP_R: begin
        w_class    = C_R;
        w_alu      = alu_of(w_f3, w_f7b);
        // funct7[5] is only meaningful for ADD/SUB and SRL/SRA.
        w_exec_bad = w_f7b && !(w_f3 == 3'b000 || w_f3 == 3'b101);
      end
      OP_IMM: begin
        w_class = C_OPIMM;
        w_src_b = 1'b1;
        w_alu   = alu_of(w_f3, (w_f3 == 3'b101) && w_f7b);
      end
      OP_LOAD: begin
        w_class = C_LOAD;
        w_src_b = 1'b1;
        w_wb    = 2'b01;
      end
      OP_STORE: begin
        w_class = C_STORE;
        w_src_b = 1'b1;
        w_imm   = 3'b001;
      end
      OP_BRANCH: begin
        w_class = C_BRANCH;
        w_imm   = 3'b010;
        case (w_f3[2:1])
          2'b00:   w_alu = ALU_SUB;
          2'b10:   w_alu = ALU_SLT;
          2'b11:   w_alu = ALU_SLTU;
          default: w_exec_bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        w_class = C_JAL;
        w_imm   = 3'b100;
        w_wb    = 2'b10;
      end
      OP_JALR: begin
        w_class = C_JALR;
        w_src_b = 1'b1;
        w_wb    = 2'b10;
      end
      OP_LUI: begin
        w_class = C_LUI;
        w_imm   = 3'b011;
        w_wb    = 2'b11;
      end
      OP_AUIPC: begin
        w_class = C_AUIPC;
        w_src_a = 2'b01;
        w_src_b = 1'b1;
        w_imm   = 3'b011;
      end
      default: ;
    endcase
  end

  // Next state and control outputs.
  always_comb begin
    w_next       = r_state;
    w_cause      = 2'b00;
    w_retire     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 1'b0;
    imm_sel      = 3'b000;
    alu_ctrl     = ALU_ADD;
    wb_sel       = 2'b00;
    trap         = 1'b0;
    trap_cause   = 2'b00;

    if (rst) begin
      w_next = S_FETCH;
    end else begin
      // Selects only matter once instr is valid and the datapath uses them.
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
        alu_src_a = w_src_a;
        alu_src_b = w_src_b;
        imm_sel   = w_imm;
        alu_ctrl  = w_alu;
        wb_sel    = w_wb;
      end
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = 2'b10;
          end
        end
        S_DECODE: begin
          if (w_class == C_BAD) begin
            w_next  = S_TRAP;
            w_cause = 2'b01;
          end else begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_exec_bad) begin
            w_next  = S_TRAP;
            w_cause = 2'b01;
          end else begin
            case (w_class)
              C_LOAD, C_STORE: w_next = S_MEM;
              C_BRANCH: begin
                pc_write = branch_taken;
                pc_src   = branch_taken ? 2'b01 : 2'b00;
                w_next   = S_FETCH;
                w_retire = 1'b1;
              end
              C_JAL, C_JALR: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = (w_class == C_JALR) ? 2'b10 : 2'b01;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
              end
              default: w_next = S_WB;
            endcase
          end
        end
        S_MEM: begin
          mem_addr_sel = 1'b1;
          mem_write    = (w_class == C_STORE);
          mem_read     = (w_class != C_STORE);
          if (mem_ready) begin
            w_next   = (w_class == C_STORE) ? S_FETCH : S_WB;
            w_retire = (w_class == C_STORE);
          end else if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = 2'b10;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          w_next    = S_FETCH;
          w_retire  = 1'b1;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = r_cause;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef MCC_MEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_wait;

  // Trap on the cycle that would bring the wait count up to TIMEOUT; a
  // mem_ready in that same cycle takes priority in the FSM.
  assign w_timeout     = (r_wait == TMO_LAST);
  assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Counts consecutive not-ready cycles; zero outside FETCH/MEM so each
  // entry into an access state starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
      r_wait <= r_wait + 16'd1;
    end else begin
      r_wait <= '0;
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7], 16'(TIMEOUT)};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_cause   <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
      if (w_cause != 2'b00) r_cause <= w_cause;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl (CNT_W=4, TIMEOUT=4). Inputs change one
// time unit after the rising edge; outputs are sampled one unit later.
// The timeout scenarios run only when MCC_MEM_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write, mem_addr_sel;
  logic        alu_src_b, trap;
  logic [1:0]  pc_src, alu_src_a, wb_sel, trap_cause;
  logic [2:0]  imm_sel, state;
  logic [3:0]  alu_ctrl;
  logic [3:0]  instret;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ret  = 0;

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_sel(imm_sel), .alu_ctrl(alu_ctrl),
    .wb_sel(wb_sel), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe snapshot packed as {ir_write,pc_write,reg_write,mem_read,mem_write}.
  function automatic logic [4:0] strobes();
    return {ir_write, pc_write, reg_write, mem_read, mem_write};
  endfunction

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0;
    #1;
    check("rst_strobes", 32'(strobes()), 32'h0);
    check("rst_trap", {30'd0, trap_cause}, 32'h0);
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    rst = 1'b0;
    exp_ret = 0;
  endtask

  // Zero-wait FETCH and DECODE for instruction i.
  task automatic fetch_decode(input string tag, input logic [31:0] i);
    instr = i; mem_ready = 1'b1;
    #1;
    check({tag, "_f_state"}, 32'(state), 32'd0);
    check({tag, "_f_strobes"}, 32'(strobes()), 32'b11010);
    check({tag, "_f_pcsrc"}, 32'(pc_src), 32'd0);
    tick();
    check({tag, "_d_state"}, 32'(state), 32'd1);
    check({tag, "_d_strobes"}, 32'(strobes()), 32'h0);
    tick();
  endtask

  // WB cycle: single register write with the given wb_sel, then retire.
  task automatic wb_retire(input string tag, input logic [1:0] wsel);
    check({tag, "_w_state"}, 32'(state), 32'd4);
    check({tag, "_w_strobes"}, 32'(strobes()), 32'b00100);
    check({tag, "_w_wbsel"}, 32'(wb_sel), 32'(wsel));
    tick();
    exp_ret = (exp_ret + 1) % 16;
    check({tag, "_ret_state"}, 32'(state), 32'd0);
    check({tag, "_instret"}, 32'(instret), 32'(exp_ret));
  endtask

  initial begin
    rst = 1'b1; instr = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    tick();
    do_reset();

    // ADDI x1,x0,5: states 0,1,2,4,0
    fetch_decode("addi", 32'h00500093);
    check("addi_e_state", 32'(state), 32'd2);
    check("addi_e_strobes", 32'(strobes()), 32'h0);
    check("addi_e_alu", 32'(alu_ctrl), 32'h0);
    check("addi_e_srcb", 32'(alu_src_b), 32'd1);
    tick();
    wb_retire("addi", 2'b00);

    // LW x1,0(x0): three wait cycles in MEM, mem_read held for four
    fetch_decode("lw", 32'h00002083);
    check("lw_e_state", 32'(state), 32'd2);
    check("lw_e_imm", 32'(imm_sel), 32'd0);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      check($sformatf("lw_m%0d_state", k), 32'(state), 32'd3);
      check($sformatf("lw_m%0d_strobes", k), 32'(strobes()), 32'b00010);
      check($sformatf("lw_m%0d_addr", k), 32'(mem_addr_sel), 32'd1);
      tick();
    end
    wb_retire("lw", 2'b01);

    // BEQ taken, then BNE not taken
    fetch_decode("beq", 32'h00000463);
    branch_taken = 1'b1;
    #1;
    check("beq_e_state", 32'(state), 32'd2);
    check("beq_e_pcw", 32'(pc_write), 32'd1);
    check("beq_e_pcsrc", 32'(pc_src), 32'd1);
    check("beq_e_alu", 32'(alu_ctrl), 32'h1);
    tick();
    branch_taken = 1'b0;
    exp_ret++;
    check("beq_ret_state", 32'(state), 32'd0);
    check("beq_instret", 32'(instret), 32'(exp_ret));
    fetch_decode("bne", 32'h00001463);
    check("bne_e_pcw", 32'(pc_write), 32'd0);
    check("bne_e_pcsrc", 32'(pc_src), 32'd0);
    check("bne_e_alu", 32'(alu_ctrl), 32'h1);
    tick();
    exp_ret++;
    check("bne_instret", 32'(instret), 32'(exp_ret));

    // SW x0,0(x0): store retires straight out of MEM
    fetch_decode("sw", 32'h00002023);
    check("sw_e_imm", 32'(imm_sel), 32'd1);
    tick();
    check("sw_m_state", 32'(state), 32'd3);
    check("sw_m_strobes", 32'(strobes()), 32'b00001);
    check("sw_m_addr", 32'(mem_addr_sel), 32'd1);
    tick();
    exp_ret++;
    check("sw_ret_state", 32'(state), 32'd0);
    check("sw_instret", 32'(instret), 32'(exp_ret));

    // SUB (R-type), SRAI, LUI, AUIPC
    fetch_decode("sub", 32'h40000033);
    check("sub_e_alu", 32'(alu_ctrl), 32'h1);
    check("sub_e_srcb", 32'(alu_src_b), 32'd0);
    tick();
    wb_retire("sub", 2'b00);
    fetch_decode("srai", 32'h40005093);
    check("srai_e_alu", 32'(alu_ctrl), 32'h7);
    tick();
    wb_retire("srai", 2'b00);
    fetch_decode("lui", 32'h000010B7);
    check("lui_e_imm", 32'(imm_sel), 32'd3);
    tick();
    wb_retire("lui", 2'b11);
    fetch_decode("auipc", 32'h00001097);
    check("auipc_e_srca", 32'(alu_src_a), 32'd1);
    check("auipc_e_imm", 32'(imm_sel), 32'd3);
    check("auipc_e_alu", 32'(alu_ctrl), 32'h0);
    tick();
    wb_retire("auipc", 2'b00);

    // JALR: link and jump in EXEC
    fetch_decode("jalr", 32'h000080E7);
    check("jalr_e_strobes", 32'(strobes()), 32'b01100);
    check("jalr_e_pcsrc", 32'(pc_src), 32'd2);
    check("jalr_e_wbsel", 32'(wb_sel), 32'd2);
    tick();
    exp_ret++;
    check("jalr_instret", 32'(instret), 32'(exp_ret));

    // 16 JALs from zero wrap the 4-bit counter back to 0
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      fetch_decode("jal", 32'h000000EF);
      if (n == 1) begin
        check("jal_e_strobes", 32'(strobes()), 32'b01100);
        check("jal_e_pcsrc", 32'(pc_src), 32'd1);
        check("jal_e_wbsel", 32'(wb_sel), 32'd2);
      end
      tick();
      if (n == 15) check("jal_instret15", 32'(instret), 32'd15);
    end
    check("jal_wrap", 32'(instret), 32'd0);

    // Illegal opcode 0x7F traps after DECODE; only reset leaves TRAP
    do_reset();
    fetch_decode("ill", 32'h00500093);
    tick(); tick();
    exp_ret = 1;
    instr = 32'h0000007F;
    #1;
    tick();
    check("ill_d_state", 32'(state), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ill_t%0d_state", k), 32'(state), 32'd5);
      check($sformatf("ill_t%0d_strobes", k), 32'(strobes()), 32'h0);
      check($sformatf("ill_t%0d_trap", k), {29'd0, trap, trap_cause}, 32'b101);
      tick();
    end
    check("ill_instret", 32'(instret), 32'd1);
    do_reset();

    // R-type with funct7[5]=1 and funct3=111 traps in EXEC
    fetch_decode("rbad", 32'h40007033);
    check("rbad_e_strobes", 32'(strobes()), 32'h0);
    tick();
    check("rbad_state", 32'(state), 32'd5);
    check("rbad_cause", 32'(trap_cause), 32'd1);
    check("rbad_instret", 32'(instret), 32'd0);
    do_reset();

`ifdef MCC_MEM_TIMEOUT_EN
    // Four not-ready FETCH cycles trap with cause 10
    instr = 32'h00500093; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("tmo_f%0d_state", k), 32'(state), 32'd0);
      tick();
    end
    check("tmo_state", 32'(state), 32'd5);
    check("tmo_cause", 32'(trap_cause), 32'd2);
    do_reset();
    // Ready on the fourth cycle completes the fetch
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      tick();
    end
    check("tmo_edge_state", 32'(state), 32'd1);
    check("tmo_edge_trap", 32'(trap), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
